// File: rtl/sbus_datapath_seq.sv
// Single-bus datapath with on-block T-state sequencer for ALU/MUL/LD/ST commands.
// Optional build macro SBUS_R0_ZERO_EN hardwires R0 to zero.
module sbus_datapath_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned RSEL_W = $clog2(NREGS)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [RSEL_W-1:0] ra,
    input  logic [RSEL_W-1:0] rb,
    input  logic [RSEL_W-1:0] rc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    input  logic              wr_en,
    input  logic [RSEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [RSEL_W:0]   dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int unsigned SH_W = $clog2(WIDTH);

`ifdef SBUS_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_LD  = 4'd7;
    localparam logic [3:0] OP_ST  = 4'd8;

    localparam int unsigned B_RA  = 0;
    localparam int unsigned B_RB  = 1;
    localparam int unsigned B_RC  = 2;
    localparam int unsigned B_ZLO = 3;
    localparam int unsigned B_MDR = 4;
    localparam int unsigned NSRC  = 5;

    logic [2:0]        state, state_nxt;
    logic [3:0]        op_q;
    logic [RSEL_W-1:0] ra_q, rb_q, rc_q;
    logic [WIDTH-1:0]  rf [NREGS];
    logic [WIDTH-1:0]  y, zhi, zlo, hi, lo, mar, mdr;
    logic [WIDTH-1:0]  rd_a, rd_b, rd_c, bus, alu_hi, alu_lo;
    logic [2*WIDTH-1:0] prod;
    logic [NSRC-1:0]   bus_sel;
    logic y_ld, z_ld, mar_ld, mdr_bus_ld, mdr_mem_ld, ra_ld, hilo_ld, done_nxt, err_nxt;

    function automatic logic wr_ok(input logic [RSEL_W-1:0] s);
        return !(R0_ZERO && (s == '0));
    endfunction

    assign rd_a = (R0_ZERO && (ra_q == '0)) ? '0 : rf[ra_q];
    assign rd_b = (R0_ZERO && (rb_q == '0)) ? '0 : rf[rb_q];
    assign rd_c = (R0_ZERO && (rc_q == '0)) ? '0 : rf[rc_q];
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

    // One-hot AND-OR bus mux; the sequencer never raises two selects at once.
    always_comb begin
        bus = '0;
        if (bus_sel[B_RA])  bus = bus | rd_a;
        if (bus_sel[B_RB])  bus = bus | rd_b;
        if (bus_sel[B_RC])  bus = bus | rd_c;
        if (bus_sel[B_ZLO]) bus = bus | zlo;
        if (bus_sel[B_MDR]) bus = bus | mdr;
    end

    assign prod = (2*WIDTH)'(y) * (2*WIDTH)'(bus);

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (op_q)
            OP_ADD:  alu_lo = y + bus;
            OP_SUB:  alu_lo = y - bus;
            OP_AND:  alu_lo = y & bus;
            OP_OR:   alu_lo = y | bus;
            OP_SHL:  alu_lo = y << bus[SH_W-1:0];
            OP_SHR:  alu_lo = y >> bus[SH_W-1:0];
            OP_MUL:  {alu_hi, alu_lo} = prod;
            default: ;
        endcase
    end

    // Sequencer: next state and per-state bus/load controls.
    always_comb begin
        state_nxt  = state;
        bus_sel    = '0;
        y_ld       = 1'b0;
        z_ld       = 1'b0;
        mar_ld     = 1'b0;
        mdr_bus_ld = 1'b0;
        mdr_mem_ld = 1'b0;
        ra_ld      = 1'b0;
        hilo_ld    = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_T1;
            S_T1: begin
                if (op_q > OP_ST) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    bus_sel[B_RB] = 1'b1;
                    if (op_q == OP_LD) begin
                        mar_ld    = 1'b1;
                        state_nxt = S_MEM;
                    end else if (op_q == OP_ST) begin
                        mar_ld    = 1'b1;
                        state_nxt = S_T2;
                    end else begin
                        y_ld      = 1'b1;
                        state_nxt = S_T2;
                    end
                end
            end
            S_T2: begin
                if (op_q == OP_ST) begin
                    bus_sel[B_RA] = 1'b1;
                    mdr_bus_ld    = 1'b1;
                    state_nxt     = S_MEM;
                end else begin
                    bus_sel[B_RC] = 1'b1;
                    z_ld          = 1'b1;
                    state_nxt     = S_T3;
                end
            end
            S_T3: begin
                if (op_q == OP_LD) begin
                    bus_sel[B_MDR] = 1'b1;
                    ra_ld          = 1'b1;
                end else if (op_q == OP_MUL) begin
                    bus_sel[B_ZLO] = 1'b1;
                    hilo_ld        = 1'b1;
                end else begin
                    bus_sel[B_ZLO] = 1'b1;
                    ra_ld          = 1'b1;
                end
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op_q == OP_ST) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        mdr_mem_ld = 1'b1;
                        state_nxt  = S_T3;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != S_IDLE);
            done    <= done_nxt;
            err     <= err_nxt;
            mem_req <= (state_nxt == S_MEM);
            mem_we  <= (state_nxt == S_MEM) && (op_q == OP_ST);
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            y   <= '0;
            zhi <= '0;
            zlo <= '0;
            hi  <= '0;
            lo  <= '0;
            mar <= '0;
            mdr <= '0;
        end else begin
            if (y_ld)   y <= bus;
            if (z_ld)   {zhi, zlo} <= {alu_hi, alu_lo};
            if (mar_ld) mar <= bus;
            if (mdr_bus_ld)      mdr <= bus;
            else if (mdr_mem_ld) mdr <= mem_rdata;
            if (hilo_ld) begin
                hi <= zhi;
                lo <= bus;
            end
        end
    end

    // Host preload only lands in IDLE and loses to a same-cycle start.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
        end else if (ra_ld) begin
            if (wr_ok(ra_q)) rf[ra_q] <= bus;
        end else if ((state == S_IDLE) && !start && wr_en && wr_ok(wr_sel)) begin
            rf[wr_sel] <= wr_data;
        end
    end

    always_comb begin
        dbg_data = '0;
        if (!dbg_sel[RSEL_W])
            dbg_data = (R0_ZERO && (dbg_sel[RSEL_W-1:0] == '0)) ? '0 : rf[dbg_sel[RSEL_W-1:0]];
        else if (dbg_sel == (RSEL_W+1)'(NREGS))
            dbg_data = hi;
        else if (dbg_sel == (RSEL_W+1)'(NREGS + 1))
            dbg_data = lo;
    end

endmodule

// File: tb/tb_sbus_datapath_seq.sv
// Directed bench for sbus_datapath_seq (default 32-bit, 16 registers).
module tb_sbus_datapath_seq;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [3:0]  ra = '0, rb = '0, rc = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  dbg_sel = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3;
    localparam logic [3:0] SHL = 4'd4, SHR = 4'd5, MUL = 4'd6, LD = 4'd7, ST = 4'd8;

    sbus_datapath_seq dut (
        .Clock(Clock), .Clear(Clear), .start(start), .op(op),
        .ra(ra), .rb(rb), .rc(rc),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic preload(input logic [3:0] s, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = s; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] s, output logic [31:0] v);
        dbg_sel = s;
        #1;
        v = dbg_data;
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        op = o; ra = a; rb = b; rc = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        if (!done) n = -1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        Clear = 1'b1;
        tick(); tick();
        Clear = 1'b0;
        checks++;
        if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, mem_req, mem_we});
        end
        rd(5'd1, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_r1: got %h expected 0", v); end
        rd(5'd16, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", v); end
    endtask

    task automatic test_add();
        int n;
        logic [31:0] v;
        preload(4'd2, 32'd7);
        preload(4'd3, 32'd5);
        issue(ADD, 4'd1, 4'd2, 4'd3);
        wait_done(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL add_latency: got %0d expected 3", n); end
        checks++;
        if ({err, busy} !== 2'b00) begin errors++; $display("FAIL add_err_busy: got %b expected 00", {err, busy}); end
        rd(5'd1, v);
        checks++;
        if (v !== 32'd12) begin errors++; $display("FAIL add_r1: got %h expected 0000000c", v); end
        // new command accepted in the done cycle
        issue(AND_, 4'd10, 4'd2, 4'd3);
        wait_done(n);
        rd(5'd10, v);
        checks++;
        if ({n, v} !== {32'd3, 32'd5}) begin errors++; $display("FAIL back_to_back_and: got n=%0d v=%h expected n=3 v=00000005", n, v); end
        issue(OR_, 4'd11, 4'd2, 4'd3);
        wait_done(n);
        rd(5'd11, v);
        checks++;
        if (v !== 32'd7) begin errors++; $display("FAIL or_r11: got %h expected 00000007", v); end
    endtask

    task automatic test_sub_shift();
        int n;
        logic [31:0] v;
        preload(4'd2, 32'd0);
        preload(4'd3, 32'd1);
        issue(SUB, 4'd4, 4'd2, 4'd3);
        wait_done(n);
        rd(5'd4, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wrap: got %h expected ffffffff", v); end
        preload(4'd5, 32'h8000_0001);
        preload(4'd6, 32'd33);
        issue(SHL, 4'd7, 4'd5, 4'd6);
        wait_done(n);
        rd(5'd7, v);
        checks++;
        if (v !== 32'h0000_0002) begin errors++; $display("FAIL shl_mod: got %h expected 00000002", v); end
        issue(SHR, 4'd12, 4'd5, 4'd6);
        wait_done(n);
        rd(5'd12, v);
        checks++;
        if (v !== 32'h4000_0000) begin errors++; $display("FAIL shr_logical: got %h expected 40000000", v); end
        preload(4'd13, 32'h10);
        issue(ADD, 4'd13, 4'd13, 4'd13);
        wait_done(n);
        rd(5'd13, v);
        checks++;
        if (v !== 32'h20) begin errors++; $display("FAIL alias_add: got %h expected 00000020", v); end
    endtask

    task automatic test_mul();
        int n;
        logic [31:0] v;
        preload(4'd1, 32'hFFFF_FFFF);
        preload(4'd2, 32'd2);
        preload(4'd3, 32'h1234);
        issue(MUL, 4'd3, 4'd1, 4'd2);
        wait_done(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL mul_latency: got %0d expected 3", n); end
        rd(5'd16, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL mul_hi: got %h expected 00000001", v); end
        rd(5'd17, v);
        checks++;
        if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_lo: got %h expected fffffffe", v); end
        rd(5'd3, v);
        checks++;
        if (v !== 32'h1234) begin errors++; $display("FAIL mul_ra_kept: got %h expected 00001234", v); end
        rd(5'd18, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL dbg_out_of_range: got %h expected 0", v); end
    endtask

    task automatic test_ld_st();
        logic [31:0] v;
        preload(4'd8, 32'h40);
        preload(4'd14, 32'h0);
        issue(LD, 4'd9, 4'd8, 4'd0);
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h40}) begin
            errors++; $display("FAIL ld_req: got req=%b we=%b addr=%h expected 1 0 00000040", mem_req, mem_we, mem_addr);
        end
        // preload attempt while busy must be dropped
        wr_en = 1'b1; wr_sel = 4'd14; wr_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({mem_req, mem_addr, done} !== {1'b1, 32'h40, 1'b0}) begin
                errors++; $display("FAIL ld_wait%0d: got req=%b addr=%h done=%b expected 1 00000040 0", i, mem_req, mem_addr, done);
            end
        end
        wr_en = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        checks++;
        if ({done, mem_req} !== 2'b00) begin errors++; $display("FAIL ld_after_ack: got done=%b req=%b expected 0 0", done, mem_req); end
        tick();
        checks++;
        if ({done, err} !== 2'b10) begin errors++; $display("FAIL ld_done: got done=%b err=%b expected 1 0", done, err); end
        rd(5'd9, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_r9: got %h expected deadbeef", v); end
        rd(5'd14, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL busy_preload: got %h expected 0", v); end
        issue(ST, 4'd9, 4'd8, 4'd0);
        tick(); tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL st_req: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000040 deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({done, err, mem_req, busy} !== 4'b1000) begin
            errors++; $display("FAIL st_done: got %b expected 1000", {done, err, mem_req, busy});
        end
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        issue(4'd12, 4'd1, 4'd2, 4'd3);
        checks++;
        if ({done, busy} !== 2'b01) begin errors++; $display("FAIL ill_t1: got done=%b busy=%b expected 0 1", done, busy); end
        tick();
        checks++;
        if ({done, err, busy} !== 3'b110) begin errors++; $display("FAIL ill_done: got %b expected 110", {done, err, busy}); end
        rd(5'd1, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ill_r1: got %h expected ffffffff", v); end
        rd(5'd16, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL ill_hi: got %h expected 00000001", v); end
        tick();
        checks++;
        if ({done, err} !== 2'b00) begin errors++; $display("FAIL ill_pulse: got %b expected 00", {done, err}); end
    endtask

    task automatic test_clear_mem();
        logic [31:0] v, acc;
        issue(LD, 4'd9, 4'd8, 4'd0);
        tick(); tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        checks++;
        if ({mem_req, mem_we, busy, done} !== 4'b0) begin
            errors++; $display("FAIL clear_ctrl: got %b expected 0000", {mem_req, mem_we, busy, done});
        end
        acc = '0;
        rd(5'd1, v);  acc = acc | v;
        rd(5'd8, v);  acc = acc | v;
        rd(5'd9, v);  acc = acc | v;
        rd(5'd16, v); acc = acc | v;
        rd(5'd17, v); acc = acc | v;
        checks++;
        if (acc !== 32'h0) begin errors++; $display("FAIL clear_regs: got or=%h expected 0", acc); end
    endtask

    task automatic test_r0();
        int n;
        logic [31:0] v, exp;
`ifdef SBUS_R0_ZERO_EN
        exp = 32'h0;
`else
        exp = 32'h5;
`endif
        preload(4'd0, 32'h5);
        rd(5'd0, v);
        checks++;
        if (v !== exp) begin errors++; $display("FAIL r0_preload: got %h expected %h", v, exp); end
        preload(4'd2, 32'd2);
        preload(4'd3, 32'd3);
        issue(ADD, 4'd0, 4'd2, 4'd3);
        wait_done(n);
        rd(5'd0, v);
        checks++;
        if (v !== exp) begin errors++; $display("FAIL r0_add: got %h expected %h", v, exp); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_shift();
        test_mul();
        test_ld_st();
        test_illegal();
        test_clear_mem();
        test_r0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbus_datapath_seq.md
Name: sbus_datapath_seq

Overview:
Parametrised next-generation single-bus datapath. It contains a WIDTH-bit register file of NREGS entries, Y, ZHI/ZLO, HI, LO, MAR and MDR, all sharing one internal bus. An on-block step sequencer runs decoded ALU, multiply, load and store commands as fixed T-state sequences, so no external per-signal bus/enable strobing is needed. Memory is reached through a req/ack handshake; a host preload port and a debug read port serve the control unit and testbenches.

Parameters:
WIDTH, 32, datapath and bus width in bits (power of 2, >=8)
NREGS, 16, number of general-purpose registers (power of 2, >=2)
RSEL_W, $clog2(NREGS), register-select width (derived; do not override)

Ports:
Clock  input  1  rising-edge clock
Clear  input  1  synchronous active-high reset
start  input  1  command valid; sampled only in IDLE
op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 MUL, 7 LD, 8 ST, 9-15 illegal
ra, rb, rc  input  RSEL_W  destination/source selects
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = illegal op
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = write, valid with mem_req
mem_addr  output  WIDTH  driven from MAR
mem_wdata  output  WIDTH  driven from MDR
mem_rdata  input  WIDTH  read data, sampled on ack
mem_ack  input  1  completes the request on the current edge
wr_en, wr_sel, wr_data  input  1/RSEL_W/WIDTH  host register preload; honoured only when busy=0
dbg_sel  input  RSEL_W+1  0..NREGS-1 = Rn; NREGS = HI; NREGS+1 = LO; others return 0
dbg_data  output  WIDTH  combinational read of the dbg_sel target

Behaviour:
- Clock and reset: single clock domain, Clock. Reset is synchronous and active-high on Clear: all registers, Y, Z, HI, LO, MAR and MDR go to 0; state goes to IDLE; busy, done, err, mem_req and mem_we are 0. Clear overrides start, wr_en and mem_ack on the same edge. Clear during a pending mem_req drops the request on the next edge.
- The bus is a priority-free one-hot mux driven only by the sequencer. At most one source drives it per state.
- States: IDLE, T1, T2, T3, MEM.
- IDLE: start=1 latches op/ra/rb/rc and moves to T1. wr_en writes Rwr_sel, but start wins if both are asserted.
- ALU ops 0-5:
  - T1: Y <= Rb.
  - T2: Z <= ALU(Y, Rc).
  - T3: Ra <= ZLO; then IDLE and done=1 in the following cycle.
  - Accept edge to writeback edge is 3 edges. done and the new Ra are visible in the same cycle. busy=0 in that cycle, and a new start is accepted in it.
- MUL: unsigned Y*Rc gives a 2*WIDTH result into ZHI:ZLO. T3 writes HI<=ZHI and LO<=ZLO; Ra is unchanged.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SHL/SHR are logical, shift amount Rc[log2(WIDTH)-1:0].
  - ZHI=0 for all non-MUL ops.
- LD:
  - T1: MAR <= Rb.
  - MEM: mem_req=1, mem_we=0; waits indefinitely; on the edge with mem_ack=1, MDR <= mem_rdata and go to T3.
  - T3: Ra <= MDR; done.
  - Minimum is 3 edges with ack in the first MEM cycle.
- ST:
  - T1: MAR <= Rb.
  - T2: MDR <= Ra.
  - MEM: mem_req=1, mem_we=1 until ack; ack goes to IDLE with done.
- Aliasing: ra==rb==rc is legal; sources are read before the writeback edge.
- Illegal op: T1 performs no writes, then IDLE with done=1 and err=1. err is 0 on every other done.
- mem_ack outside MEM is ignored. start while busy is ignored (no queueing).

Optional Feature:
SBUS_R0_ZERO_EN
- Defined: R0 is hardwired to 0. Writes to R0 from any source (writeback, LD, wr_en) are discarded; all reads of R0 return 0.
- Undefined: R0 is an ordinary register.

Test Plan:
- Preload R2=7, R3=5; start ADD ra=1 rb=2 rc=3 -> done exactly 3 edges after accept, R1=12, err=0, busy low in the done cycle.
- R2=0, R3=1, SUB ra=4 -> R4=0xFFFFFFFF. Then R5=0x80000001, R6=33, SHL ra=7 rb=5 rc=6 -> R7=0x00000002.
- R1=0xFFFFFFFF, R2=2, MUL rb=1 rc=2 -> HI=0x00000001, LO=0xFFFFFFFE, Ra unchanged.
- R8=0x40, LD ra=9 rb=8; hold mem_ack low 4 cycles then pulse it with mem_rdata=0xDEADBEEF -> mem_addr=0x40 and mem_req steady throughout, R9=0xDEADBEEF, done on the edge after ack. ST R9 -> mem[R8] -> mem_we=1, mem_wdata=0xDEADBEEF.
- op=12 -> done with err=1 after 2 edges, no register changes. Assert Clear during MEM of an LD -> next cycle mem_req=0, busy=0, all registers 0.
- With SBUS_R0_ZERO_EN: wr_en R0=5 then ADD ra=0 -> dbg R0 reads 0. Without the macro: R0 reads 5.
